// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, IF/ID register, branch resolve, HLT freeze
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_PC_write_en,
    input  logic        i_IFID_write_en,
    input  logic [2:0]  i_Flags,
    input  logic [15:0] i_BR_target,
    input  logic [15:0] i_Imem_data,
    output logic [15:0] o_Imem_addr,
    output logic [15:0] o_IFID_instr,
    output logic [15:0] o_IFID_PC_plus2,
    output logic        o_IFID_valid,
    output logic        o_Branch_taken,
    output logic        o_Halt
);
    typedef enum logic {S_RUN, S_HALTED} state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_ifid_instr;
    logic [15:0] r_ifid_pc_plus2;
    logic        r_ifid_valid;

    logic [3:0]  w_opcode;
    logic [2:0]  w_ccc;
    logic [8:0]  w_imm9;
    logic        w_z, w_v, w_n;
    logic        w_cond_met;
    logic        w_is_b, w_is_br;
    logic        w_branch_taken;
    logic [15:0] w_target;
    logic [15:0] w_pc_plus2;
    logic        w_fetched_hlt;

    assign w_opcode = r_ifid_instr[15:12];
    assign w_ccc    = r_ifid_instr[11:9];
    assign w_imm9   = r_ifid_instr[8:0];
    assign w_z      = i_Flags[2];
    assign w_v      = i_Flags[1];
    assign w_n      = i_Flags[0];

    always_comb begin
        w_cond_met = 1'b0;
        case (w_ccc)
            3'b000:  w_cond_met = !w_z;
            3'b001:  w_cond_met = w_z;
            3'b010:  w_cond_met = !w_z && !w_n;
            3'b011:  w_cond_met = w_n;
            3'b100:  w_cond_met = w_z || (!w_z && !w_n);
            3'b101:  w_cond_met = w_n || w_z;
            3'b110:  w_cond_met = w_v;
            default: w_cond_met = 1'b1;
        endcase
    end

    assign w_is_b         = r_ifid_valid && (w_opcode == 4'b1100);
    assign w_is_br        = r_ifid_valid && (w_opcode == 4'b1101);
    // A stalled branch must not redirect; it resolves once the stall lifts.
    assign w_branch_taken = (w_is_b || w_is_br) && w_cond_met && i_PC_write_en;
    assign w_target       = w_is_br ? i_BR_target
                                    : r_ifid_pc_plus2 + {{6{w_imm9[8]}}, w_imm9, 1'b0};
    assign w_pc_plus2     = r_pc + 16'd2;
    assign w_fetched_hlt  = (i_Imem_data[15:12] == 4'hF) && i_PC_write_en && !w_branch_taken;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc            <= RESET_PC;
            r_ifid_instr    <= 16'h0000;
            r_ifid_pc_plus2 <= 16'h0000;
            r_ifid_valid    <= 1'b0;
            r_state         <= S_RUN;
        end else begin
            if (!i_PC_write_en)
                r_pc <= r_pc;
            else if (w_branch_taken)
                r_pc <= w_target;
            else if (r_state == S_HALTED || w_fetched_hlt)
                r_pc <= r_pc;
            else
                r_pc <= w_pc_plus2;

            if (w_branch_taken || (i_IFID_write_en && r_state == S_HALTED)) begin
                r_ifid_instr    <= 16'h0000;
                r_ifid_pc_plus2 <= 16'h0000;
                r_ifid_valid    <= 1'b0;
            end else if (i_IFID_write_en) begin
                r_ifid_instr    <= i_Imem_data;
                r_ifid_pc_plus2 <= w_pc_plus2;
                r_ifid_valid    <= 1'b1;
            end

            if (r_state == S_RUN && w_fetched_hlt)
                r_state <= S_HALTED;
        end
    end

    assign o_Imem_addr     = r_pc;
    assign o_IFID_instr    = r_ifid_instr;
    assign o_IFID_PC_plus2 = r_ifid_pc_plus2;
    assign o_IFID_valid    = r_ifid_valid;
    assign o_Branch_taken  = w_branch_taken;
    assign o_Halt          = (r_state == S_HALTED);
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the five-stage pipeline.
- Owns the PC register and the IF/ID pipeline register.
- Resolves B/BR branches for the instruction held in IF/ID and flushes the wrong-path fetch.
- Obeys the hazard detector's PC_write_en/IFID_write_en stall controls, and freezes fetch on HLT.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- PC_write_en  in  1  from hazard detector; 0 = hold PC (stall).
- IFID_write_en  in  1  from hazard detector; 0 = hold IF/ID (stall).
- Flags  in  3  architectural flags {Z,V,N}, already up to date when no stall is requested.
- BR_target  in  16  register-file read data for IF/ID instr[7:4] (BR target).
- Imem_data  in  16  instruction word at Imem_addr; combinational memory read.
- Imem_addr  out  16  equals PC.
- IFID_instr  out  16  instruction in IF/ID.
- IFID_PC_plus2  out  16  PC+2 of the instruction in IF/ID.
- IFID_valid  out  1  IF/ID holds a real instruction; 0 = bubble.
- Branch_taken  out  1  combinational; redirect this cycle.
- Halt  out  1  registered; fetch halted.

Behaviour:
- Reset (async):
  - PC=RESET_PC; IFID_instr=16'h0000; IFID_PC_plus2=16'h0000.
  - IFID_valid=0; Halt=0; state=RUN.
  - Reset mid-halt or mid-stall returns to this state immediately.
- Branch decode (on IF/ID): opcode=IFID_instr[15:12]; ccc=[11:9]; imm9=[8:0].
  - Candidate if IFID_valid and opcode is 1100 (B) or 1101 (BR).
- Condition met, Z/V/N from Flags:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GTE: Z=1 or (Z=0 and N=0)
  - 101 LTE: N=1 or Z=1
  - 110 OVF: V=1
  - 111 unconditional: always met
- Branch_taken = candidate and condition met and PC_write_en.
  - While stalled, a branch never resolves; it re-evaluates when the stall ends.
- Target:
  - B: IFID_PC_plus2 + (sign_extend(imm9) << 1), modulo 2^16 (wrap allowed).
  - BR: BR_target, used unaltered.
- Next PC, in priority order:
  1. PC_write_en=0: hold.
  2. Branch_taken: target.
  3. state=HALTED or fetched HLT: hold.
  4. Otherwise: PC+2, modulo 2^16 (0xFFFE -> 0x0000).
- IF/ID next value, in priority order:
  1. Branch_taken: load bubble (instr 0, valid 0, PC_plus2 0). This overrides IFID_write_en.
  2. IFID_write_en=0: hold.
  3. state=HALTED: load bubble.
  4. Otherwise: load Imem_data, PC+2, valid=1.
- Fetched HLT: Imem_data[15:12]=1111 and PC_write_en=1 and not Branch_taken.
- State machine RUN/HALTED:
  - RUN -> HALTED on fetched HLT. The HLT word itself enters IF/ID in that edge.
  - An HLT on the wrong path of a taken branch is squashed; state stays RUN.
  - HALTED: PC frozen at the HLT address; IF/ID fills with bubbles.
  - Exit HALTED only by rst.
- Halt = (state==HALTED).
- Stall followed by branch: with PC_write_en=0 and IFID_write_en=0, PC and IF/ID are unchanged, so Imem_addr is stable and the same fetch repeats.
- Latency: fetch to IF/ID is 1 cycle. Taken-branch penalty is 1 bubble.

Test Plan:
- Reset, Imem returns 16'h1234 at every address, both enables high.
  -> Imem_addr 0,2,4,6 on successive cycles; IFID_PC_plus2 2,4,6; IFID_valid=1 from cycle 1.
- Hold PC_write_en=IFID_write_en=0 for 2 cycles at PC=0x0006.
  -> PC and IF/ID unchanged for 2 cycles; resume at 0x0008.
- IF/ID=B EQ with imm9=0x1FE (-2), IFID_PC_plus2=0x0010, Flags Z=1.
  -> Branch_taken=1; next PC=0x000C; next IFID_valid=0.
  -> Same with Z=0: not taken; PC+2 path.
- IF/ID=BR unconditional (ccc=111), BR_target=0xABCE, while PC_write_en=0.
  -> Branch_taken=0, PC held.
  -> After the stall releases: PC=0xABCE, one bubble.
- HLT at 0x0020 -> Halt=1 after the edge; PC stays 0x0020; IF/ID holds HLT, then bubbles.
  -> HLT fetched while IF/ID holds a taken B -> squashed, Halt stays 0.
- Assert rst while HALTED and mid-stall -> PC=0x0000, Halt=0, IFID_valid=0 immediately (asynchronous).
